// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port unified instruction/data memory between the
//   instruction-fetch port and the load/store port of the multi-cycle core.
//   Each granted request is latched, a fixed MEM_LAT-cycle memory access is
//   sequenced, and the result is returned with a one-cycle ack pulse.
//
// Parameters:
//   ADDR_W  - byte-address width of all address ports
//   MEM_LAT - memory access cycles (>= 1)
//
// Ports:
//   clk, rst                  - clock (rising edge), async active-low reset
//   if_req/if_addr            - fetch request and byte address
//   if_rdata/if_ack           - fetched word, one-cycle completion pulse
//   d_req/d_we/d_funct3       - data request, store select, access size/sign
//   d_addr/d_wdata            - data byte address and store data
//   d_rdata/d_ack             - load data, one-cycle completion pulse
//   mem_en/mem_we/mem_funct3  - memory enable, write strobe, access size
//   mem_addr/mem_wdata        - memory byte address and write data
//   mem_rdata                 - memory read data, valid in last access cycle
//   busy                      - arbiter not idle
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate based
//                        on the previous grant; otherwise data always wins.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W        = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic        OWN_FETCH    = 1'b0;
  localparam logic        OWN_DATA     = 1'b1;
  localparam logic [2:0]  FETCH_FUNCT3 = 3'b010;

  // A zero-latency memory cannot be sequenced by the down-counter.
  generate
    if (MEM_LAT < 1) begin : g_lat_check
      $error("unified_mem_arbiter: MEM_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                busy_q, busy_d;
  logic                grant_data_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On conflict, grant whichever side did not win last time.
  always_comb begin
    grant_data_c = d_req && (!if_req || (last_owner_q == OWN_FETCH));
  end
`else
  // Data wins conflicts: it belongs to the older instruction.
  always_comb begin
    grant_data_c = d_req;
  end
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_DATA;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ACC;
          cnt_d   = CNT_W'(MEM_LAT);
          if (grant_data_c) begin
            owner_d  = OWN_DATA;
            addr_d   = d_addr;
            we_d     = d_we;
            funct3_d = d_funct3;
            wdata_d  = d_wdata;
          end else begin
            owner_d  = OWN_FETCH;
            addr_d   = if_addr;
            we_d     = 1'b0;
            funct3_d = FETCH_FUNCT3;
            wdata_d  = '0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = grant_data_c ? OWN_DATA : OWN_FETCH;
`endif
        end
      end
      ACC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they align with ACC.
    mem_en_d = (state_d == ACC);
    mem_we_d = (state_d == ACC) && (owner_d == OWN_DATA) && we_d &&
               (cnt_d == CNT_W'(1));
    busy_d   = (state_d != IDLE);
  end

  assign if_rdata   = if_rdata_q;
  assign if_ack     = if_ack_q;
  assign d_rdata    = d_rdata_q;
  assign d_ack      = d_ack_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_funct3 = funct3_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter: instance A uses MEM_LAT=1,
// instance B uses MEM_LAT=3; each has its own word-addressed memory model.
module tb_unified_mem_arbiter;

  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A signals (MEM_LAT = 1)
  logic          a_rst, a_if_req, a_if_ack, a_d_req, a_d_we, a_d_ack;
  logic          a_mem_en, a_mem_we, a_busy;
  logic [AW-1:0] a_if_addr, a_d_addr, a_mem_addr;
  logic [2:0]    a_d_funct3, a_mem_funct3;
  logic [31:0]   a_if_rdata, a_d_wdata, a_d_rdata, a_mem_wdata, a_mem_rdata;

  // Instance B signals (MEM_LAT = 3)
  logic          b_rst, b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack;
  logic          b_mem_en, b_mem_we, b_busy;
  logic [AW-1:0] b_if_addr, b_d_addr, b_mem_addr;
  logic [2:0]    b_d_funct3, b_mem_funct3;
  logic [31:0]   b_if_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;

  unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .d_req(a_d_req), .d_we(a_d_we), .d_funct3(a_d_funct3), .d_addr(a_d_addr),
    .d_wdata(a_d_wdata), .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_funct3(a_mem_funct3),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy)
  );

  unified_mem_arbiter #(.ADDR_W(AW), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_funct3(b_d_funct3), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_funct3(b_mem_funct3),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  // Memory models: combinational read, write on mem_we, bench preload port.
  bit   [31:0]   a_mem [128];
  bit   [31:0]   b_mem [128];
  logic          pl_en = 1'b0;
  logic          pl_sel = 1'b0;
  logic [6:0]    pl_idx = '0;
  logic [31:0]   pl_data = '0;
  int            a_we_cnt = 0;
  int            b_we_cnt = 0;
  int            b_dack_cnt = 0;

  assign a_mem_rdata = a_mem[a_mem_addr[AW-1:2]];
  assign b_mem_rdata = b_mem[b_mem_addr[AW-1:2]];

  always @(posedge clk) begin
    if (a_mem_we) a_mem[a_mem_addr[AW-1:2]] <= a_mem_wdata;
    else if (pl_en && !pl_sel) a_mem[pl_idx] <= pl_data;
  end

  always @(posedge clk) begin
    if (b_mem_we) b_mem[b_mem_addr[AW-1:2]] <= b_mem_wdata;
    else if (pl_en && pl_sel) b_mem[pl_idx] <= pl_data;
  end

  always @(posedge clk) if (a_mem_we) a_we_cnt <= a_we_cnt + 1;
  always @(posedge clk) if (b_mem_we) b_we_cnt <= b_we_cnt + 1;
  always @(posedge clk) if (b_d_ack)  b_dack_cnt <= b_dack_cnt + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [6:0] idx, input logic [31:0] data);
    pl_sel  = sel;
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    tick(1);
    pl_en   = 1'b0;
  endtask

  initial begin
    a_rst = 1'b0; a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_funct3 = '0; a_d_addr = '0; a_d_wdata = '0;
    b_rst = 1'b0; b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_funct3 = '0; b_d_addr = '0; b_d_wdata = '0;
    #2;

    // Reset state
    chk("rst_a_mem_en",   32'(a_mem_en), 32'd0);
    chk("rst_a_mem_we",   32'(a_mem_we), 32'd0);
    chk("rst_a_busy",     32'(a_busy), 32'd0);
    chk("rst_a_acks",     32'({a_if_ack, a_d_ack}), 32'd0);
    chk("rst_a_rdata",    a_if_rdata | a_d_rdata, 32'd0);
    chk("rst_a_mem_addr", 32'(a_mem_addr), 32'd0);
    chk("rst_b_busy",     32'(b_busy), 32'd0);

    preload(1'b0, 7'h01, 32'h00A0_0093);
    preload(1'b1, 7'h08, 32'hCAFE_F00D);
    a_rst = 1'b1;
    b_rst = 1'b1;
    tick(1);

    // A: fetch 0x004
    a_if_req = 1'b1; a_if_addr = 9'h004;
    tick(1);
    chk("f_mem_en",     32'(a_mem_en), 32'd1);
    chk("f_mem_addr",   32'(a_mem_addr), 32'h004);
    chk("f_mem_funct3", 32'(a_mem_funct3), 32'd2);
    chk("f_mem_we",     32'(a_mem_we), 32'd0);
    chk("f_busy",       32'(a_busy), 32'd1);
    chk("f_ack_early",  32'(a_if_ack), 32'd0);
    tick(1);
    chk("f_if_ack",     32'(a_if_ack), 32'd1);
    chk("f_if_rdata",   a_if_rdata, 32'h00A0_0093);
    chk("f_d_ack",      32'(a_d_ack), 32'd0);
    chk("f_mem_en_off", 32'(a_mem_en), 32'd0);
    a_if_req = 1'b0;
    tick(1);
    chk("f_ack_pulse",  32'(a_if_ack), 32'd0);
    chk("f_idle",       32'(a_busy), 32'd0);

    // A: store 0xDEADBEEF to 0x100, then load it back
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_funct3 = 3'b010; a_d_addr = 9'h100;
    a_d_wdata = 32'hDEAD_BEEF;
    tick(1);
    chk("st_mem_we",    32'(a_mem_we), 32'd1);
    chk("st_mem_addr",  32'(a_mem_addr), 32'h100);
    chk("st_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    tick(1);
    chk("st_d_ack",     32'(a_d_ack), 32'd1);
    chk("st_we_cnt",    32'(a_we_cnt), 32'd1);
    chk("st_d_rdata",   a_d_rdata, 32'd0);
    chk("st_mem_we_off", 32'(a_mem_we), 32'd0);
    a_d_req = 1'b0;
    tick(1);
    a_d_req = 1'b1; a_d_we = 1'b0;
    tick(1);
    chk("ld_mem_we",    32'(a_mem_we), 32'd0);
    tick(1);
    chk("ld_d_ack",     32'(a_d_ack), 32'd1);
    chk("ld_d_rdata",   a_d_rdata, 32'hDEAD_BEEF);
    a_d_req = 1'b0;
    tick(1);

    // A: simultaneous fetch 0x004 and load 0x100
    a_if_req = 1'b1; a_if_addr = 9'h004;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 9'h100;
    tick(2);
`ifdef ARB_ROUND_ROBIN_EN
    chk("cf1_if_ack",   32'(a_if_ack), 32'd1);
    chk("cf1_d_ack",    32'(a_d_ack), 32'd0);
    chk("cf1_rdata",    a_if_rdata, 32'h00A0_0093);
    a_if_req = 1'b0;
`else
    chk("cf1_d_ack",    32'(a_d_ack), 32'd1);
    chk("cf1_if_ack",   32'(a_if_ack), 32'd0);
    chk("cf1_rdata",    a_d_rdata, 32'hDEAD_BEEF);
    a_d_req = 1'b0;
`endif
    tick(1);
    chk("cf_resp_gap",  32'(a_busy), 32'd0);
    tick(1);
    chk("cf2_busy",     32'(a_busy), 32'd1);
    chk("cf2_no_ack",   32'({a_if_ack, a_d_ack}), 32'd0);
    tick(1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("cf2_d_ack",    32'(a_d_ack), 32'd1);
    chk("cf2_if_ack",   32'(a_if_ack), 32'd0);
    chk("cf2_rdata",    a_d_rdata, 32'hDEAD_BEEF);
    a_d_req = 1'b0;
`else
    chk("cf2_if_ack",   32'(a_if_ack), 32'd1);
    chk("cf2_d_ack",    32'(a_d_ack), 32'd0);
    chk("cf2_rdata",    a_if_rdata, 32'h00A0_0093);
    a_if_req = 1'b0;
`endif
    tick(1);

    // B: load 0x020 with MEM_LAT=3
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_funct3 = 3'b010; b_d_addr = 9'h020;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("l3_mem_en%0d", i), 32'(b_mem_en), 32'd1);
      chk($sformatf("l3_busy%0d", i),   32'(b_busy), 32'd1);
      chk($sformatf("l3_we%0d", i),     32'(b_mem_we), 32'd0);
      chk($sformatf("l3_ack%0d", i),    32'(b_d_ack), 32'd0);
    end
    tick(1);
    chk("l3_d_ack",     32'(b_d_ack), 32'd1);
    chk("l3_d_rdata",   b_d_rdata, 32'hCAFE_F00D);
    chk("l3_mem_en_off", 32'(b_mem_en), 32'd0);
    chk("l3_busy_resp", 32'(b_busy), 32'd1);
    b_d_req = 1'b0;
    tick(1);
    chk("l3_idle",      32'(b_busy), 32'd0);
    chk("l3_we_cnt",    32'(b_we_cnt), 32'd0);

    // B: store 0x12345678 to 0x040, payload altered and req dropped mid-access
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 9'h040; b_d_wdata = 32'h1234_5678;
    tick(1);
    chk("pc_we_c3",     32'(b_mem_we), 32'd0);
    chk("pc_addr_c3",   32'(b_mem_addr), 32'h040);
    b_d_req = 1'b0; b_d_addr = 9'h080; b_d_wdata = 32'hFFFF_FFFF;
    tick(1);
    chk("pc_we_c2",     32'(b_mem_we), 32'd0);
    chk("pc_addr_c2",   32'(b_mem_addr), 32'h040);
    tick(1);
    chk("pc_we_c1",     32'(b_mem_we), 32'd1);
    chk("pc_wdata_c1",  b_mem_wdata, 32'h1234_5678);
    chk("pc_addr_c1",   32'(b_mem_addr), 32'h040);
    tick(1);
    chk("pc_d_ack",     32'(b_d_ack), 32'd1);
    chk("pc_we_cnt",    32'(b_we_cnt), 32'd1);
    chk("pc_d_rdata",   b_d_rdata, 32'hCAFE_F00D);
    tick(1);
    chk("pc_mem_040",   b_mem[7'h10], 32'h1234_5678);
    chk("pc_mem_080",   b_mem[7'h20], 32'd0);
    chk("pc_ack_cnt",   32'(b_dack_cnt), 32'd2);
    chk("pc_idle",      32'(b_busy), 32'd0);

    // B: reset asserted while a store is in flight (cnt = 2)
    b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 9'h060; b_d_wdata = 32'h0000_0055;
    tick(2);
    chk("ar_pre_en",    32'(b_mem_en), 32'd1);
    b_rst = 1'b0; b_d_req = 1'b0;
    #1;
    chk("ar_mem_en",    32'(b_mem_en), 32'd0);
    chk("ar_mem_we",    32'(b_mem_we), 32'd0);
    chk("ar_busy",      32'(b_busy), 32'd0);
    chk("ar_acks",      32'({b_if_ack, b_d_ack}), 32'd0);
    chk("ar_mem_addr",  32'(b_mem_addr), 32'd0);
    chk("ar_d_rdata",   b_d_rdata, 32'd0);
    tick(2);
    chk("ar_we_cnt",    32'(b_we_cnt), 32'd1);
    chk("ar_mem_060",   b_mem[7'h18], 32'd0);
    chk("ar_ack_cnt",   32'(b_dack_cnt), 32'd2);
    b_rst = 1'b1;
    tick(1);
    b_if_req = 1'b1; b_if_addr = 9'h020;
    tick(1);
    chk("ar_f_en",      32'(b_mem_en), 32'd1);
    chk("ar_f_funct3",  32'(b_mem_funct3), 32'd2);
    tick(2);
    chk("ar_f_early",   32'(b_if_ack), 32'd0);
    tick(1);
    chk("ar_f_ack",     32'(b_if_ack), 32'd1);
    chk("ar_f_rdata",   b_if_rdata, 32'hCAFE_F00D);
    chk("ar_f_we_cnt",  32'(b_we_cnt), 32'd1);
    b_if_req = 1'b0;
    tick(1);
    chk("ar_f_idle",    32'(b_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the core's instruction-fetch port and its load/store port.
- Latches each request, sequences a fixed-latency memory access and returns data with a one-cycle ack pulse.
- Sits between the core and the unified memory, replacing separate instr/data memories for the multi-cycle core variant.

Parameters:
ADDR_W, 9, byte-address width on all address ports
MEM_LAT, 1, memory access cycles; legal range ≥1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch byte address
if_rdata  out  32  fetched instruction; valid while if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held until d_ack
d_we  in  1  1=store, 0=load
d_funct3  in  3  access size/sign, passed to memory
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data
d_rdata  out  32  load data; valid while d_ack=1
d_ack  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access active
mem_we  out  1  memory write strobe
mem_funct3  out  3  size to memory (3'b010 for fetch)
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid in last access cycle
busy  out  1  arbiter not in IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, owner=0, all outputs 0, rdata registers 0, last_owner=DATA. An in-flight access is dropped and mem_we falls immediately.
- States:
  - IDLE: at a clock edge with any req=1, latch owner, addr, we, funct3 and wdata, load cnt=MEM_LAT, and go to ACC. With no request, stay in IDLE.
  - ACC: mem_en=1. mem_addr/mem_funct3/mem_wdata come from the latch registers. cnt decrements each edge. mem_we=1 only when owner=DATA, we=1 and cnt==1, giving exactly one write. At the edge with cnt==1, capture mem_rdata into the owner's rdata register (loads/fetches only; a store leaves d_rdata unchanged), set the owner's ack, and go to RESP.
  - RESP: the owner's ack=1 for exactly this cycle; requests are ignored; go to IDLE at the next edge.
- Timing: if req is sampled at edge k, ack is high during cycle k+MEM_LAT to k+MEM_LAT+1. The earliest next grant is at edge k+MEM_LAT+2.
- Conflict (both reqs at the same IDLE edge): DATA wins, because it belongs to the older instruction. The losing req stays pending and is granted after RESP.
- Requester must hold req and its payload stable until ack. The arbiter latches the payload at grant, so later changes are ignored. If req drops mid-ACC, the access still completes and ack still pulses.
- Fetch accesses always drive mem_funct3=3'b010 and mem_we=0.
- Outputs:
  - busy = (state != IDLE).
  - mem_en, mem_we and mem_* are functions of state and registers only; there is no combinational path from req to mem_*.
  - ack outputs are registered.
- cnt width is $clog2(MEM_LAT+1). MEM_LAT=0 is unsupported; an elaboration-time check is required.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - On conflict, grant the requester that is not last_owner.
  - last_owner updates at every grant.
  - Reset value is DATA, so the first conflict after reset goes to FETCH.
- Undefined: fixed DATA priority; last_owner is not implemented.

Test Plan:
- MEM_LAT=1, memory word @0x004=0x00A00093, if_req with if_addr=0x004 → mem_en high 1 cycle; if_ack pulses 2 cycles after grant edge with if_rdata=0x00A00093; d_ack stays 0.
- MEM_LAT=1, d_req store d_addr=0x100, d_wdata=0xDEADBEEF, funct3=010 → exactly one mem_we pulse, addr 0x100; d_ack pulse; a following load of 0x100 returns 0xDEADBEEF.
- if_req and d_req at the same edge (no RR) → data access first (d_ack), then fetch (if_ack) at earliest 2 cycles later; with ARB_ROUND_ROBIN_EN, the first conflict after reset grants fetch first.
- MEM_LAT=3, load d_addr=0x020 → mem_en high 3 cycles, mem_we never high, d_ack at cycle 4 after grant, busy high 4 cycles.
- MEM_LAT=3, store in progress (cnt=2), rst pulsed low → all outputs 0 immediately, no mem_we pulse, no ack; after release, state IDLE and a new fetch completes normally.
- req deasserted after grant, payload changed mid-ACC → memory sees original latched addr/data; ack still pulses once.
